// File: rtl/axis_video_pkg.sv
// Shared types and defaults for the AXIS video stages in the camera path.
// Holds the framing FSM state, the beat payload layout and default widths.
package axis_video_pkg;

  localparam int C_AXIS_DATA_WIDTH = 64;
  localparam int C_CNT_WIDTH       = 16;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0] tdata;
    logic                         tuser;
    logic                         tlast;
  } axis_beat_t;

endpackage

// File: rtl/axis_frame_marker_if.sv
// AXI4-Stream video bundle; master drives valid/data/sideband and slave drives ready.
// The slave side of the marker ignores tuser/tlast because the raw pixel stream carries no framing.
interface axis_frame_marker_if #(
  parameter int P_DATA_WIDTH = axis_video_pkg::C_AXIS_DATA_WIDTH
);

  logic                    tvalid;
  logic                    tready;
  logic [P_DATA_WIDTH-1:0] tdata;
  logic                    tuser;
  logic                    tlast;

  modport master (
    output tvalid,
    output tdata,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tuser,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer with registered outputs: 1-cycle latency, 1 beat/clk sustained.
// in_rdy comes only from registered occupancy, so no ready path crosses the buffer.
module axis_skid_buf #(
  parameter int P_WIDTH = 66
) (
  input  logic               i_axis_clk,
  input  logic               i_axis_rstn,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [P_WIDTH-1:0] in_dat,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [P_WIDTH-1:0] out_dat
);

  logic [1:0]         occ_q;
  logic [P_WIDTH-1:0] head_q;
  logic [P_WIDTH-1:0] tail_q;
  logic               push;
  logic               pop;

  assign in_rdy  = (occ_q != 2'd2);
  assign out_vld = (occ_q != 2'd0);
  assign out_dat = head_q;
  assign push    = in_vld & in_rdy;
  assign pop     = out_vld & out_rdy;

  always_ff @(posedge i_axis_clk) begin
    if (!i_axis_rstn) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_q <= in_dat;
          end else begin
            tail_q <= in_dat;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        // Push and pop together only happen at occupancy 1: the new beat replaces the head.
        2'b11: head_q <= in_dat;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_frame_marker.sv
// Adds tuser (start of frame) and tlast (end of line) to a raw pixel stream; 1-cycle latency.
// Upstream is drained and dropped outside a frame; in RUN, upstream ready follows the skid buffer.
module axis_frame_marker
  import axis_video_pkg::*;
#(
  parameter int P_AXIS_DATA_WIDTH = C_AXIS_DATA_WIDTH,
  parameter int P_CNT_WIDTH       = C_CNT_WIDTH
) (
  input  logic                   i_axis_clk,
  input  logic                   i_axis_rstn,
  input  logic                   i_ena,
  input  logic [P_CNT_WIDTH-1:0] i_beats_per_line,
  input  logic [P_CNT_WIDTH-1:0] i_lines_per_frame,
  axis_frame_marker_if.slave     s_axis,
  axis_frame_marker_if.master    m_axis,
  output logic [P_CNT_WIDTH-1:0] o_frame_cnt,
  output logic                   o_busy,
  output logic                   o_err_cfg
);

  localparam int                     LP_PAYLOAD_W = P_AXIS_DATA_WIDTH + 2;
  localparam logic [P_CNT_WIDTH-1:0] LP_ONE       = P_CNT_WIDTH'(1);

  state_t                  state_q;
  logic [P_CNT_WIDTH-1:0]  beat_cnt_q;
  logic [P_CNT_WIDTH-1:0]  line_cnt_q;
  logic [P_CNT_WIDTH-1:0]  bpl_q;
  logic [P_CNT_WIDTH-1:0]  lpf_q;
  logic [P_CNT_WIDTH-1:0]  frame_cnt_q;
  logic                    busy_q;
  logic                    err_cfg_q;

  logic                    cfg_ok;
  logic                    last_beat;
  logic                    last_line;
  logic                    skid_in_vld;
  logic                    skid_in_rdy;
  logic                    run_accept;
  logic [LP_PAYLOAD_W-1:0] skid_in_dat;
  logic                    skid_out_vld;
  logic [LP_PAYLOAD_W-1:0] skid_out_dat;
  logic                    unused_s_side;

  assign cfg_ok    = (i_beats_per_line != '0) && (i_lines_per_frame != '0);
  assign last_beat = (beat_cnt_q == bpl_q - LP_ONE);
  assign last_line = (line_cnt_q == lpf_q - LP_ONE);

  assign skid_in_vld   = (state_q == RUN) && s_axis.tvalid;
  assign run_accept    = skid_in_vld && skid_in_rdy;
  assign s_axis.tready = (state_q == RUN) ? skid_in_rdy : 1'b1;
  assign skid_in_dat   = {s_axis.tdata, (beat_cnt_q == '0) && (line_cnt_q == '0), last_beat};
  assign unused_s_side = s_axis.tuser ^ s_axis.tlast;

  axis_skid_buf #(
    .P_WIDTH (LP_PAYLOAD_W)
  ) u_skid (
    .i_axis_clk  (i_axis_clk),
    .i_axis_rstn (i_axis_rstn),
    .in_vld      (skid_in_vld),
    .in_rdy      (skid_in_rdy),
    .in_dat      (skid_in_dat),
    .out_vld     (skid_out_vld),
    .out_rdy     (m_axis.tready),
    .out_dat     (skid_out_dat)
  );

  assign m_axis.tvalid                              = skid_out_vld;
  assign {m_axis.tdata, m_axis.tuser, m_axis.tlast} = skid_out_dat;

  assign o_frame_cnt = frame_cnt_q;
  assign o_busy      = busy_q;
  assign o_err_cfg   = err_cfg_q;

  always_ff @(posedge i_axis_clk) begin
    if (!i_axis_rstn) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      line_cnt_q  <= '0;
      bpl_q       <= '0;
      lpf_q       <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
      err_cfg_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_ena) begin
            if (cfg_ok) begin
              bpl_q      <= i_beats_per_line;
              lpf_q      <= i_lines_per_frame;
              beat_cnt_q <= '0;
              line_cnt_q <= '0;
              state_q    <= RUN;
              busy_q     <= 1'b1;
            end else begin
              err_cfg_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (run_accept) begin
            if (last_beat) begin
              beat_cnt_q <= '0;
              if (last_line) begin
                // Frame boundary: the only point where enable and config are looked at again.
                line_cnt_q  <= '0;
                frame_cnt_q <= frame_cnt_q + LP_ONE;
                if (i_ena && cfg_ok) begin
                  bpl_q <= i_beats_per_line;
                  lpf_q <= i_lines_per_frame;
                end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  if (i_ena) begin
                    err_cfg_q <= 1'b1;
                  end
                end
              end else begin
                line_cnt_q <= line_cnt_q + LP_ONE;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + LP_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_marker.sv
// Directed bench for axis_frame_marker: framing, stalls, idle drain, config error and mid-frame reset.
module tb_axis_frame_marker;
  import axis_video_pkg::*;

  localparam int DW = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ena;
  logic [CW-1:0] bpl;
  logic [CW-1:0] lpf;
  logic [CW-1:0] frame_cnt;
  logic          busy;
  logic          err_cfg;

  axis_frame_marker_if #(.P_DATA_WIDTH(DW)) s_if ();
  axis_frame_marker_if #(.P_DATA_WIDTH(DW)) m_if ();

  axis_frame_marker #(
    .P_AXIS_DATA_WIDTH (DW),
    .P_CNT_WIDTH       (CW)
  ) dut (
    .i_axis_clk        (clk),
    .i_axis_rstn       (rstn),
    .i_ena             (ena),
    .i_beats_per_line  (bpl),
    .i_lines_per_frame (lpf),
    .s_axis            (s_if),
    .m_axis            (m_if),
    .o_frame_cnt       (frame_cnt),
    .o_busy            (busy),
    .o_err_cfg         (err_cfg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  axis_beat_t got_q[$];
  axis_beat_t held;
  int  ncnt      = 0;
  int  first_s   = -1;
  int  first_m   = -1;
  int  s_acc     = 0;
  int  occ       = 0;
  int  rdy_bad   = 0;
  int  stall_bad = 0;
  int  stall_cnt = 0;
  bit  m_vld_seen = 1'b0;
  bit  s_fell     = 1'b0;
  bit  prev_stall = 1'b0;
  bit  snd_done   = 1'b0;
  logic [15:0] tready_pat = 16'b1100_0100_0111_0010;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, mirrors skid occupancy and records emitted beats.
  initial begin
    forever begin
      @(negedge clk);
      ncnt++;
      if (!rstn) begin
        occ        = 0;
        prev_stall = 1'b0;
      end else begin
        if (m_if.tvalid) m_vld_seen = 1'b1;
        if (prev_stall) begin
          stall_cnt++;
          if (!m_if.tvalid || m_if.tdata !== held.tdata || m_if.tuser !== held.tuser ||
              m_if.tlast !== held.tlast)
            stall_bad++;
        end
        prev_stall  = m_if.tvalid && !m_if.tready;
        held.tdata  = m_if.tdata;
        held.tuser  = m_if.tuser;
        held.tlast  = m_if.tlast;
        if (busy) begin
          if (s_if.tready !== (occ < 2)) rdy_bad++;
          if (!s_if.tready) s_fell = 1'b1;
        end
        if (s_if.tvalid && s_if.tready) begin
          s_acc++;
          if (first_s < 0) first_s = ncnt;
          if (busy) occ++;
        end
        if (m_if.tvalid && first_m < 0) first_m = ncnt;
        if (m_if.tvalid && m_if.tready) begin
          got_q.push_back(held);
          occ--;
        end
      end
    end
  end

  task automatic send_beat(input int d);
    bit rdy;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 64'(d);
    for (int guard = 0; guard < 200; guard++) begin
      @(negedge clk);
      rdy = s_if.tready;
      @(posedge clk);
      #1;
      if (rdy) return;
    end
    check_val("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic send_burst(input int base, input int n);
    for (int i = 0; i < n; i++) send_beat(base + i);
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    for (int guard = 0; guard < 200 && got_q.size() < n; guard++) begin
      @(posedge clk);
      #1;
    end
    if (got_q.size() < n) check_val(tag, 64'(got_q.size()), 64'(n));
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input int base, input int n,
                              input int bpl_e, input int lpf_e, input int off);
    axis_beat_t b;
    int idx;
    check_val({tag, "_count"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && got_q.size() > 0; i++) begin
      b   = got_q.pop_front();
      idx = i + off;
      check_val($sformatf("%s_dat%0d", tag, i), b.tdata, 64'(base + i));
      check_val($sformatf("%s_usr%0d", tag, i), 64'(b.tuser), 64'((idx % (bpl_e * lpf_e)) == 0));
      check_val($sformatf("%s_lst%0d", tag, i), 64'(b.tlast), 64'((idx % bpl_e) == bpl_e - 1));
    end
    got_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    rstn = 1'b0;
    ena  = 1'b0;
    bpl  = 16'd4;
    lpf  = 16'd3;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_tvalid", 64'(m_if.tvalid), 64'(0));
    check_val("rst_tuser", 64'(m_if.tuser), 64'(0));
    check_val("rst_tlast", 64'(m_if.tlast), 64'(0));
    check_val("rst_tdata", m_if.tdata, 64'(0));
    check_val("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_err", 64'(err_cfg), 64'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    ena  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("t1_busy", 64'(busy), 64'(1));

    // 4x3 frame, continuous flow
    first_s = -1;
    first_m = -1;
    got_q.delete();
    send_burst(0, 12);
    wait_out(12, "t1_drain");
    check_stream("t1", 0, 12, 4, 3, 0);
    check_val("t1_frame_cnt", 64'(frame_cnt), 64'(1));
    check_val("t1_latency", 64'(first_m - first_s), 64'(1));
    check_val("t1_busy_after", 64'(busy), 64'(1));

    // Same config with downstream stalls
    stall_bad = 0;
    stall_cnt = 0;
    s_fell    = 1'b0;
    snd_done  = 1'b0;
    fork
      begin
        send_burst(100, 12);
        snd_done = 1'b1;
      end
      begin
        for (int k = 0; k < 500 && !snd_done; k++) begin
          @(posedge clk);
          #1;
          m_if.tready = tready_pat[k % 16];
        end
        m_if.tready = 1'b1;
      end
    join
    wait_out(12, "t2_drain");
    check_stream("t2", 100, 12, 4, 3, 0);
    check_val("t2_frame_cnt", 64'(frame_cnt), 64'(2));
    check_val("t2_stall_seen", 64'(stall_cnt > 0), 64'(1));
    check_val("t2_stall_stable", 64'(stall_bad), 64'(0));
    check_val("t2_s_tready_fell", 64'(s_fell), 64'(1));
    check_val("t2_s_tready_model", 64'(rdy_bad), 64'(0));

    // Enable dropped mid-frame
    send_burst(200, 6);
    ena = 1'b0;
    send_burst(206, 6);
    wait_out(12, "t4_drain");
    check_stream("t4", 200, 12, 4, 3, 0);
    check_val("t4_frame_cnt", 64'(frame_cnt), 64'(3));
    check_val("t4_busy", 64'(busy), 64'(0));

    // Idle drain
    m_vld_seen = 1'b0;
    s_acc      = 0;
    send_burst(700, 5);
    repeat (4) @(posedge clk);
    #1;
    check_val("t3_accepted", 64'(s_acc), 64'(5));
    check_val("t3_m_tvalid", 64'(m_vld_seen), 64'(0));
    check_val("t3_got", 64'(got_q.size()), 64'(0));
    check_val("t3_busy", 64'(busy), 64'(0));

    // Zero beats-per-line
    bpl = 16'd0;
    ena = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("t5_err", 64'(err_cfg), 64'(1));
    check_val("t5_busy", 64'(busy), 64'(0));
    m_vld_seen = 1'b0;
    send_burst(600, 2);
    repeat (4) @(posedge clk);
    #1;
    check_val("t5_m_tvalid", 64'(m_vld_seen), 64'(0));

    // Reset in the middle of a frame
    bpl = 16'd4;
    repeat (2) @(posedge clk);
    #1;
    check_val("t6_busy", 64'(busy), 64'(1));
    send_burst(300, 6);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 64'(306);
    rstn        = 1'b0;
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    @(negedge clk);
    check_val("t6_rst_tvalid", 64'(m_if.tvalid), 64'(0));
    check_val("t6_rst_tuser", 64'(m_if.tuser), 64'(0));
    check_val("t6_rst_tlast", 64'(m_if.tlast), 64'(0));
    check_val("t6_rst_tdata", m_if.tdata, 64'(0));
    check_val("t6_rst_frame_cnt", 64'(frame_cnt), 64'(0));
    check_val("t6_rst_busy", 64'(busy), 64'(0));
    check_val("t6_rst_err", 64'(err_cfg), 64'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    got_q.delete();
    send_burst(400, 4);
    wait_out(4, "t6a_drain");
    check_stream("t6a", 400, 4, 4, 3, 0);
    check_val("t6a_frame_cnt", 64'(frame_cnt), 64'(0));

    // Config changed mid-frame only takes effect at the next frame: 1x1
    bpl = 16'd1;
    lpf = 16'd1;
    send_burst(404, 8);
    wait_out(8, "t6b_drain");
    check_stream("t6b", 404, 8, 4, 3, 4);
    check_val("t6b_frame_cnt", 64'(frame_cnt), 64'(1));
    send_burst(500, 3);
    wait_out(3, "t7_drain");
    check_stream("t7", 500, 3, 1, 1, 0);
    check_val("t7_frame_cnt", 64'(frame_cnt), 64'(4));
    check_val("t7_busy", 64'(busy), 64'(1));
    check_val("end_s_tready_model", 64'(rdy_bad), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_marker.md
Name: axis_frame_marker

Overview:
- Sits directly downstream of the DVP-to-AXIS FIFO stage in the camera path, on the AXIS read clock.
- Receives the raw packed pixel stream, which carries no framing, and counts beats per line and lines per frame against a runtime configuration.
- Emits an AXI4-Stream video stream with tuser (start of frame) and tlast (end of line), suitable for a VDMA S2MM channel.
- Outside a frame, it drains and discards upstream data so the FIFO cannot back up.

Parameters:
- P_AXIS_DATA_WIDTH, 64, tdata width on both sides.
- P_CNT_WIDTH, 16, width of the beat, line and frame counters and of the config inputs.

Ports:
- i_axis_clk  in  1  single clock for the whole block.
- i_axis_rstn  in  1  synchronous, active-low reset.
- i_ena  in  1  enable framing; sampled only at frame boundaries.
- i_beats_per_line  in  P_CNT_WIDTH  beats per line; must be non-zero.
- i_lines_per_frame  in  P_CNT_WIDTH  lines per frame; must be non-zero.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- s_axis_tdata  in  P_AXIS_DATA_WIDTH  upstream data.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  P_AXIS_DATA_WIDTH  downstream data.
- m_axis_tuser  out  1  start of frame, set on the first beat of each frame.
- m_axis_tlast  out  1  end of line, set on the last beat of each line.
- o_frame_cnt  out  P_CNT_WIDTH  number of completed frames; wraps.
- o_busy  out  1  high while in RUN.
- o_err_cfg  out  1  sticky flag: an enable was attempted with a zero config field.

Behaviour:
- Reset (i_axis_rstn=0 at a clock edge) sets: state=IDLE, all counters=0, o_frame_cnt=0, o_busy=0, o_err_cfg=0.
- Reset also empties the skid buffer, so m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0.
- Reset is honoured mid-frame; any partial frame is discarded with no tlast.
- State IDLE:
  - s_axis_tready=1; every accepted beat is dropped; nothing reaches the master side.
  - If i_ena=1 and both config fields are non-zero: latch the config into shadow registers, clear the beat and line counters, go to RUN.
  - If i_ena=1 and either config field is zero: set o_err_cfg and stay in IDLE.
- State RUN:
  - s_axis_tready equals the skid buffer's input ready.
  - Each accepted beat is pushed into the skid buffer together with:
    - tuser = (beat==0 && line==0)
    - tlast = (beat==beats_per_line-1)
  - Beat counter increments on each accepted beat and wraps to 0 after the tlast beat.
  - Line counter increments on each tlast beat.
- Frame end (tlast beat with line==lines_per_frame-1):
  - o_frame_cnt increments, wrapping modulo 2^P_CNT_WIDTH.
  - i_ena is re-sampled in that same cycle.
  - If i_ena=1 and the config is valid: relatch the config, stay in RUN, next beat carries tuser.
  - Otherwise: go to IDLE.
- Deasserting i_ena mid-frame has no effect until the frame completes, so frames are never truncated.
- Config inputs may change at any time; only the shadow copies are used in RUN.
- o_busy = (state==RUN).
- o_err_cfg clears only on reset.
- Skid buffer:
  - 2-entry, registered outputs.
  - Latency from s-side handshake to m_axis_tvalid is 1 cycle.
  - Sustains 1 beat/clk under continuous m_axis_tready=1.
  - Input ready depends only on registered occupancy; there is no combinational tready path from m to s.
  - Data, tuser and tlast are held stable while m_axis_tvalid=1 and m_axis_tready=0.
  - Beats already in the skid buffer when the state returns to IDLE still drain to the master side.
- Simultaneous accept and emit at occupancy 1 keeps occupancy at 1.
- beats_per_line=1: every beat carries tlast.
- lines_per_frame=1 and beats_per_line=1: every beat carries both tuser and tlast.

Decomposition:
- Package axis_video_pkg contains:
  - typedef enum state_t {IDLE, RUN}
  - struct axis_beat_t {tdata, tuser, tlast}
  - localparam defaults for the counter width
- Sub-module axis_skid_buf, parameterised by payload width. It is reusable for the other AXIS stages in the ip directory.

Test Plan:
- Config 4 beats x 3 lines, i_ena=1, continuous valid/ready, data = incrementing 0..11 -> 12 beats out in order; tuser only on data 0; tlast on data 3, 7, 11; o_frame_cnt=1; first m_axis_tvalid 1 cycle after first handshake.
- Same config, m_axis_tready toggling 1-0 pseudo-randomly -> no beat lost or duplicated; tdata/tuser/tlast stable while stalled; s_axis_tready falls once 2 beats are buffered.
- i_ena=0, 5 upstream beats -> all 5 accepted (s_axis_tready=1); m_axis_tvalid stays 0; o_busy=0.
- i_ena dropped after beat 5 of a 12-beat frame -> remaining beats 6..11 still framed and emitted; then IDLE; subsequent beats dropped; o_frame_cnt=1.
- i_beats_per_line=0, i_ena=1 -> o_err_cfg=1, state stays IDLE, nothing emitted; after reset o_err_cfg=0.
- i_axis_rstn=0 asserted on beat 6 of a frame, then released with i_ena=1 -> all outputs at reset values; next accepted beat carries tuser=1; o_frame_cnt restarts from 0.
